// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the RV32I instruction decoder.
//   Opcodes, funct7 values, ALU operation codes, write-back select codes,
//   data-memory size codes and the packed decoded-control payload.
package ctrl_pkg;

  localparam int unsigned INST_W   = 32;
  localparam int unsigned OPC_W    = 7;
  localparam int unsigned F3_W     = 3;
  localparam int unsigned F7_W     = 7;
  localparam int unsigned ALU_W    = 5;
  localparam int unsigned WB_W     = 2;
  localparam int unsigned MSZ_W    = 2;

  // Major opcodes (inst[6:0])
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_FENCE  = 7'b0001111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

  // funct7 values accepted by shift/arith encodings
  localparam logic [F7_W-1:0] F7_ZERO = 7'b0000000;
  localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;

  // ALU codes: {class[1:0], funct3}
  localparam logic [ALU_W-1:0] ALU_ADD   = 5'b00000;
  localparam logic [ALU_W-1:0] ALU_SUB   = 5'b01000;
  localparam logic [ALU_W-1:0] ALU_SLL   = 5'b00001;
  localparam logic [ALU_W-1:0] ALU_SLT   = 5'b00010;
  localparam logic [ALU_W-1:0] ALU_SLTU  = 5'b00011;
  localparam logic [ALU_W-1:0] ALU_XOR   = 5'b00100;
  localparam logic [ALU_W-1:0] ALU_SRL   = 5'b00101;
  localparam logic [ALU_W-1:0] ALU_SRA   = 5'b01101;
  localparam logic [ALU_W-1:0] ALU_OR    = 5'b00110;
  localparam logic [ALU_W-1:0] ALU_AND   = 5'b00111;
  localparam logic [ALU_W-1:0] ALU_LUI   = 5'b10000;
  localparam logic [ALU_W-1:0] ALU_AUIPC = 5'b10001;
  localparam logic [1:0]       ALU_CLS_BR = 2'b11;

  // Write-back source select
  localparam logic [WB_W-1:0] WB_ALU = 2'b00;
  localparam logic [WB_W-1:0] WB_MEM = 2'b01;
  localparam logic [WB_W-1:0] WB_PC4 = 2'b10;

  // Data-memory access size
  localparam logic [MSZ_W-1:0] MEM_BYTE = 2'b00;
  localparam logic [MSZ_W-1:0] MEM_HALF = 2'b01;
  localparam logic [MSZ_W-1:0] MEM_WORD = 2'b10;

  // Decoded control payload
  typedef struct packed {
    logic [ALU_W-1:0] alu_ctrl;
    logic             reg_file_wr_en;
    logic [WB_W-1:0]  reg_file_wr_back_sel;
    logic             alu_op2_sel;
    logic             d_mem_sz_ex;
    logic             d_mem_wr_en;
    logic [MSZ_W-1:0] d_mem_size;
    logic             jal;
    logic             jalr;
  } ctrl_sig_t;

endpackage

// File: rtl/ctrl_if.sv
// ctrl_if: instruction in, decoded controls out.
//   master: drives inst, observes controls (fetch side / testbench).
//   slave : receives inst, drives controls (ctrl_unit).
interface ctrl_if;
  logic [31:0] inst;
  logic [4:0]  alu_ctrl;
  logic        reg_file_wr_en;
  logic [1:0]  reg_file_wr_back_sel;
  logic        alu_op2_sel;
  logic        d_mem_sz_ex;
  logic        d_mem_wr_en;
  logic [1:0]  d_mem_size;
  logic        jal;
  logic        jalr;
  logic        illegal_inst;
  logic        illegal_seen;

  modport master (
    output inst,
    input  alu_ctrl, reg_file_wr_en, reg_file_wr_back_sel, alu_op2_sel,
           d_mem_sz_ex, d_mem_wr_en, d_mem_size, jal, jalr,
           illegal_inst, illegal_seen
  );

  modport slave (
    input  inst,
    output alu_ctrl, reg_file_wr_en, reg_file_wr_back_sel, alu_op2_sel,
           d_mem_sz_ex, d_mem_wr_en, d_mem_size, jal, jalr,
           illegal_inst, illegal_seen
  );
endinterface

// File: rtl/ctrl_legal_chk.sv
// ctrl_legal_chk: flags RV32I encodings the core does not accept.
//   opcode    in  7  inst[6:0]
//   funct3    in  3  inst[14:12]
//   funct7    in  7  inst[31:25]
//   illegal_c out 1  combinational illegal flag
module ctrl_legal_chk
  import ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  input  logic [F3_W-1:0]  funct3,
  input  logic [F7_W-1:0]  funct7,
  output logic             illegal_c
);

  // Unknown opcodes (including any with inst[1:0] != 11) fall to default.
  always_comb begin
    illegal_c = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_FENCE, OPC_SYSTEM: illegal_c = 1'b0;
      OPC_JALR:   illegal_c = (funct3 != 3'b000);
      OPC_BRANCH: illegal_c = (funct3 == 3'b010) || (funct3 == 3'b011);
      OPC_LOAD:   illegal_c = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                              (funct3 == 3'b111);
      OPC_STORE:  illegal_c = funct3[2] || (funct3 == 3'b011);
      OPC_OP_IMM: begin
        case (funct3)
          3'b001:  illegal_c = (funct7 != F7_ZERO);
          3'b101:  illegal_c = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
          default: illegal_c = 1'b0;
        endcase
      end
      // SUB/SRA are the only funct7=0100000 forms
      OPC_OP:     illegal_c = !((funct7 == F7_ZERO) ||
                                ((funct7 == F7_ALT) &&
                                 ((funct3 == 3'b000) || (funct3 == 3'b101))));
      default:    illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_unit.sv
// ctrl_unit: RV32I main decoder with sticky illegal-instruction flag.
//   clk  in  core clock
//   rst  in  synchronous active-high reset (clears illegal_seen only)
//   bus  ctrl_if.slave: inst in; alu_ctrl, reg_file_wr_en,
//        reg_file_wr_back_sel, alu_op2_sel, d_mem_sz_ex, d_mem_wr_en,
//        d_mem_size, jal, jalr, illegal_inst (combinational) and
//        illegal_seen (registered) out
module ctrl_unit
  import ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  ctrl_if.slave  bus
);

  logic [INST_W-1:0] inst;
  logic [OPC_W-1:0]  opcode;
  logic [F3_W-1:0]   funct3;
  logic [F7_W-1:0]   funct7;
  logic              illegal_c;
  logic              illegal_seen_d;
  logic              illegal_seen_q;
  logic              unused_inst_bits;
  ctrl_sig_t         sig;

  assign inst             = bus.inst;
  assign opcode           = inst[6:0];
  assign funct3           = inst[14:12];
  assign funct7           = inst[31:25];
  // Register indices and immediates are not needed for control decode
  assign unused_inst_bits = ^{inst[24:15], inst[11:7]};

  ctrl_legal_chk u_legal_chk (
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .illegal_c (illegal_c)
  );

  // Opcode decode; an illegal encoding collapses to an all-zero NOP.
  always_comb begin
    sig = '0;
    case (opcode)
      OPC_LUI: begin
        sig.alu_ctrl       = ALU_LUI;
        sig.reg_file_wr_en = 1'b1;
        sig.alu_op2_sel    = 1'b1;
      end
      OPC_AUIPC: begin
        sig.alu_ctrl       = ALU_AUIPC;
        sig.reg_file_wr_en = 1'b1;
        sig.alu_op2_sel    = 1'b1;
      end
      OPC_JAL: begin
        sig.jal                  = 1'b1;
        sig.reg_file_wr_en       = 1'b1;
        sig.reg_file_wr_back_sel = WB_PC4;
        sig.alu_ctrl             = ALU_ADD;
      end
      OPC_JALR: begin
        sig.jalr                 = 1'b1;
        sig.reg_file_wr_en       = 1'b1;
        sig.reg_file_wr_back_sel = WB_PC4;
        sig.alu_op2_sel          = 1'b1;
        sig.alu_ctrl             = ALU_ADD;
      end
      OPC_BRANCH: begin
        sig.alu_ctrl = {ALU_CLS_BR, funct3};
      end
      OPC_LOAD: begin
        sig.reg_file_wr_en       = 1'b1;
        sig.reg_file_wr_back_sel = WB_MEM;
        sig.alu_op2_sel          = 1'b1;
        sig.alu_ctrl             = ALU_ADD;
        sig.d_mem_size           = funct3[1:0];
        sig.d_mem_sz_ex          = ~funct3[2];
      end
      OPC_STORE: begin
        sig.d_mem_wr_en = 1'b1;
        sig.d_mem_size  = funct3[1:0];
        sig.alu_op2_sel = 1'b1;
        sig.alu_ctrl    = ALU_ADD;
      end
      OPC_OP_IMM: begin
        sig.reg_file_wr_en = 1'b1;
        sig.alu_op2_sel    = 1'b1;
        // inst[30] selects SRAI only; ADDI etc. ignore immediate bit 10
        sig.alu_ctrl       = {1'b0, inst[30] & (funct3 == 3'b101), funct3};
      end
      OPC_OP: begin
        sig.reg_file_wr_en = 1'b1;
        sig.alu_ctrl       = {1'b0, inst[30], funct3};
      end
      default: sig = '0;
    endcase
    if (illegal_c) begin
      sig = '0;
    end
  end

  assign illegal_seen_d = illegal_seen_q | illegal_c;

  // Sticky illegal flag; reset wins over a coincident illegal instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_seen_q <= 1'b0;
    end else begin
      illegal_seen_q <= illegal_seen_d;
    end
  end

  assign bus.alu_ctrl             = sig.alu_ctrl;
  assign bus.reg_file_wr_en       = sig.reg_file_wr_en;
  assign bus.reg_file_wr_back_sel = sig.reg_file_wr_back_sel;
  assign bus.alu_op2_sel          = sig.alu_op2_sel;
  assign bus.d_mem_sz_ex          = sig.d_mem_sz_ex;
  assign bus.d_mem_wr_en          = sig.d_mem_wr_en;
  assign bus.d_mem_size           = sig.d_mem_size;
  assign bus.jal                  = sig.jal;
  assign bus.jalr                 = sig.jalr;
  assign bus.illegal_inst         = illegal_c;
  assign bus.illegal_seen         = illegal_seen_q;

endmodule

// File: tb/tb_ctrl_unit.sv
// tb_ctrl_unit: directed vector table, sticky-flag sequences and random
// instructions checked against a mnemonic-level decode model.
module tb_ctrl_unit;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic seen_m;
  logic [31:0] cur_inst;

  ctrl_if bus ();

  ctrl_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Field order: alu(5) wr(1) wb(2) op2(1) szex(1) mwr(1) size(2) jal jalr ill
  function automatic logic [15:0] enc(input logic [4:0] alu, input logic wr,
      input logic [1:0] wb, input logic op2, input logic szex, input logic mwr,
      input logic [1:0] sz, input logic jal, input logic jalr, input logic ill);
    return {alu, wr, wb, op2, szex, mwr, sz, jal, jalr, ill};
  endfunction

  function automatic vec_t mk(input string n, input logic [31:0] i,
                              input logic [15:0] e);
    vec_t v;
    v.name = n;
    v.inst = i;
    v.exp  = e;
    return v;
  endfunction

  function automatic logic [15:0] observed();
    return {bus.alu_ctrl, bus.reg_file_wr_en, bus.reg_file_wr_back_sel,
            bus.alu_op2_sel, bus.d_mem_sz_ex, bus.d_mem_wr_en, bus.d_mem_size,
            bus.jal, bus.jalr, bus.illegal_inst};
  endfunction

  // Mnemonic-level decode model
  function automatic logic [15:0] ref_decode(input logic [31:0] i);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [15:0] ill;
    op  = i[6:0];
    f3  = i[14:12];
    f7  = i[31:25];
    ill = 16'h0001;
    case (op)
      7'h37: return enc(5'h10, 1, 2'd0, 1, 0, 0, 2'd0, 0, 0, 0);
      7'h17: return enc(5'h11, 1, 2'd0, 1, 0, 0, 2'd0, 0, 0, 0);
      7'h6F: return enc(5'h00, 1, 2'd2, 0, 0, 0, 2'd0, 1, 0, 0);
      7'h67: return (f3 == 3'd0) ? enc(5'h00, 1, 2'd2, 1, 0, 0, 2'd0, 0, 1, 0) : ill;
      7'h63: return (f3 inside {3'd2, 3'd3}) ? ill :
                    enc({2'b11, f3}, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0);
      7'h03: return (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ?
                    enc(5'h00, 1, 2'd1, 1, !f3[2], 0, f3[1:0], 0, 0, 0) : ill;
      7'h23: return (f3 <= 3'd2) ?
                    enc(5'h00, 0, 2'd0, 1, 0, 1, f3[1:0], 0, 0, 0) : ill;
      7'h13: begin
        if (f3 == 3'd1 && f7 != 7'h00) return ill;
        if (f3 == 3'd5 && !(f7 inside {7'h00, 7'h20})) return ill;
        if (f3 == 3'd5 && f7 == 7'h20)
          return enc({2'b01, f3}, 1, 2'd0, 1, 0, 0, 2'd0, 0, 0, 0);
        return enc({2'b00, f3}, 1, 2'd0, 1, 0, 0, 2'd0, 0, 0, 0);
      end
      7'h33: begin
        if (f7 == 7'h00)
          return enc({2'b00, f3}, 1, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0);
        if (f7 == 7'h20 && (f3 inside {3'd0, 3'd5}))
          return enc({2'b01, f3}, 1, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0);
        return ill;
      end
      7'h0F, 7'h73: return 16'h0000;
      default: return ill;
    endcase
  endfunction

  task automatic chk(input string name, input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s inst=%08h got=%04h want=%04h", name, cur_inst, got, exp);
    end
  endtask

  // One cycle: drive at negedge, check comb outputs and the flag's current
  // value, then advance the flag model across the posedge.
  task automatic step(input string name, input logic [31:0] i,
                      input logic r, input logic [15:0] exp);
    @(negedge clk);
    cur_inst = i;
    bus.inst = i;
    rst      = r;
    #1;
    chk(name, observed(), exp);
    chk({name, "_seen"}, 16'(bus.illegal_seen), 16'(seen_m));
    @(posedge clk);
    seen_m = r ? 1'b0 : (seen_m | exp[0]);
  endtask

  task automatic seen_now(input string name, input logic exp);
    #1;
    chk(name, 16'(bus.illegal_seen), 16'(exp));
  endtask

  logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                           7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

  initial begin
    logic [31:0] ri;

    tbl.push_back(mk("lui",    32'h80000037, enc(5'h10, 1, 2'd0, 1, 0, 0, 2'd0, 0, 0, 0)));
    tbl.push_back(mk("auipc",  32'h80000017, enc(5'h11, 1, 2'd0, 1, 0, 0, 2'd0, 0, 0, 0)));
    tbl.push_back(mk("jal",    32'h8020006F, enc(5'h00, 1, 2'd2, 0, 0, 0, 2'd0, 1, 0, 0)));
    tbl.push_back(mk("jalr",   32'h80000067, enc(5'h00, 1, 2'd2, 1, 0, 0, 2'd0, 0, 1, 0)));
    tbl.push_back(mk("beq",    32'h800000E3, enc(5'h18, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0)));
    tbl.push_back(mk("bne",    32'h00001063, enc(5'h19, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0)));
    tbl.push_back(mk("bltu",   32'h00006063, enc(5'h1E, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0)));
    tbl.push_back(mk("lb",     32'h80000003, enc(5'h00, 1, 2'd1, 1, 1, 0, 2'd0, 0, 0, 0)));
    tbl.push_back(mk("lhu",    32'h00005003, enc(5'h00, 1, 2'd1, 1, 0, 0, 2'd1, 0, 0, 0)));
    tbl.push_back(mk("lw",     32'h00002003, enc(5'h00, 1, 2'd1, 1, 1, 0, 2'd2, 0, 0, 0)));
    tbl.push_back(mk("sb",     32'h80000823, enc(5'h00, 0, 2'd0, 1, 0, 1, 2'd0, 0, 0, 0)));
    tbl.push_back(mk("sw",     32'h00002023, enc(5'h00, 0, 2'd0, 1, 0, 1, 2'd2, 0, 0, 0)));
    tbl.push_back(mk("sltiu",  32'h80003013, enc(5'h03, 1, 2'd0, 1, 0, 0, 2'd0, 0, 0, 0)));
    tbl.push_back(mk("srai",   32'h41005013, enc(5'h0D, 1, 2'd0, 1, 0, 0, 2'd0, 0, 0, 0)));
    tbl.push_back(mk("srli",   32'h00105013, enc(5'h05, 1, 2'd0, 1, 0, 0, 2'd0, 0, 0, 0)));
    tbl.push_back(mk("addi30", 32'h40000013, enc(5'h00, 1, 2'd0, 1, 0, 0, 2'd0, 0, 0, 0)));
    tbl.push_back(mk("sub",    32'h40000033, enc(5'h08, 1, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0)));
    tbl.push_back(mk("sra",    32'h40005033, enc(5'h0D, 1, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0)));
    tbl.push_back(mk("and",    32'h00007033, enc(5'h07, 1, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0)));
    tbl.push_back(mk("fence",  32'h0000000F, 16'h0000));
    tbl.push_back(mk("ecall",  32'h00000073, 16'h0000));
    tbl.push_back(mk("jalr_f3", 32'h80001067, 16'h0001));
    tbl.push_back(mk("br_f3_2", 32'h00002063, 16'h0001));
    tbl.push_back(mk("ld",      32'h00003003, 16'h0001));
    tbl.push_back(mk("sd",      32'h00003023, 16'h0001));
    tbl.push_back(mk("slli_f7", 32'h40001013, 16'h0001));
    tbl.push_back(mk("sll_f7",  32'h40001033, 16'h0001));
    tbl.push_back(mk("mul",     32'h02000033, 16'h0001));
    tbl.push_back(mk("zero",    32'h00000000, 16'h0001));
    tbl.push_back(mk("lui_lo",  32'h80000036, 16'h0001));

    // Initial reset with a legal instruction on the bus
    rst      = 1'b1;
    cur_inst = 32'h80000037;
    bus.inst = cur_inst;
    repeat (2) @(posedge clk);
    seen_m = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen_now("reset_seen", 1'b0);

    foreach (tbl[k]) step(tbl[k].name, tbl[k].inst, 1'b0, tbl[k].exp);

    // Sticky behaviour and reset priority
    step("rst_clr", 32'h80000037, 1'b1, enc(5'h10, 1, 2'd0, 1, 0, 0, 2'd0, 0, 0, 0));
    seen_now("seen_after_rst", 1'b0);
    step("ill_a", 32'h00000000, 1'b0, 16'h0001);
    seen_now("seen_rise", 1'b1);
    step("hold_lui", 32'h80000037, 1'b0, enc(5'h10, 1, 2'd0, 1, 0, 0, 2'd0, 0, 0, 0));
    step("hold_sub", 32'h40000033, 1'b0, enc(5'h08, 1, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0));
    seen_now("seen_hold", 1'b1);
    step("rst_ill", 32'h00000000, 1'b1, 16'h0001);
    seen_now("seen_rst_ill", 1'b0);
    step("rst_ill2", 32'h40001033, 1'b1, 16'h0001);
    seen_now("seen_rst_ill2", 1'b0);

    // Random instructions, mostly on real opcodes with plausible funct7
    for (int n = 0; n < 400; n++) begin
      ri = $urandom;
      if ($urandom_range(0, 7) != 0) ri[6:0] = ops[$urandom_range(0, 10)];
      case ($urandom_range(0, 2))
        0: ri[31:25] = 7'h00;
        1: ri[31:25] = 7'h20;
        default: ;
      endcase
      step("rand", ri, ($urandom_range(0, 19) == 0), ref_decode(ri));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_unit.md
Name: ctrl_unit

Overview:
Main instruction decoder for the single-cycle RV32I core. It takes the 32-bit fetched instruction and combinationally produces ALU, register-file write-back, data-memory and jump control signals. It also flags illegal encodings. A sticky register records whether any illegal instruction has been decoded since reset.

Parameters:
None. Encodings are shared constants in ctrl_pkg.

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
inst  in  32  instruction word
alu_ctrl  out  5  ALU operation code
reg_file_wr_en  out  1  register-file write enable
reg_file_wr_back_sel  out  2  write-back source: 00 ALU, 01 data memory, 10 PC+4, 11 reserved (never driven)
alu_op2_sel  out  1  ALU operand B: 0 = rs2, 1 = immediate
d_mem_sz_ex  out  1  load sign-extend (1 = signed)
d_mem_wr_en  out  1  data-memory write enable
d_mem_size  out  2  access size: 00 byte, 01 half, 10 word
jal  out  1  JAL instruction
jalr  out  1  JALR instruction
illegal_inst  out  1  current inst is illegal (combinational)
illegal_seen  out  1  sticky illegal flag (registered)

Behaviour:
- All outputs except illegal_seen are purely combinational from inst, with zero latency. Reset has no effect on them.
- ALU opcode format is alu_ctrl = {class[1:0], f3}:
  - Arithmetic: ADD 00000, SUB 01000, SLL 00001, SLT 00010, SLTU 00011, XOR 00100, SRL 00101, SRA 01101, OR 00110, AND 00111.
  - Special: LUI pass-immediate 10000; AUIPC PC+imm 10001.
  - Branch compare: {2'b11, funct3}, i.e. BEQ 11000, BNE 11001, BLT 11100, BGE 11101, BLTU 11110, BGEU 11111.
- Default for every combinational output is 0. Each opcode then overrides the following:
  - LUI 0110111: alu 10000, wr_en 1, op2_sel 1.
  - AUIPC 0010111: alu 10001, wr_en 1, op2_sel 1.
  - JAL 1101111: jal 1, wr_en 1, wb 10, alu ADD.
  - JALR 1100111: funct3 must be 000. Outputs jalr 1, wr_en 1, wb 10, op2_sel 1, alu ADD.
  - BRANCH 1100011: funct3 must not be 010 or 011. Outputs alu {11, funct3}, op2_sel 0, wr_en 0.
  - LOAD 0000011: funct3 must be one of 000, 001, 010, 100, 101. Outputs wr_en 1, wb 01, op2_sel 1, alu ADD, d_mem_size = funct3[1:0], d_mem_sz_ex = ~funct3[2].
  - STORE 0100011: funct3 must be 000, 001 or 010. Outputs d_mem_wr_en 1, d_mem_size = funct3[1:0], op2_sel 1, alu ADD.
  - OP-IMM 0010011: wr_en 1, op2_sel 1, alu {1'b0, inst[30]&(funct3==101), funct3}.
    - SLLI requires inst[31:25] = 0000000.
    - SRLI/SRAI require inst[31:25] to be 0000000 or 0100000.
  - OP 0110011: wr_en 1, op2_sel 0, alu {1'b0, inst[30], funct3}.
    - inst[31:25] must be 0000000.
    - inst[31:25] may instead be 0100000, but only for funct3 000 or 101.
  - FENCE 0001111 and SYSTEM 1110011: legal, all outputs 0 (NOP).
- Any other opcode, or any violated constraint above, makes the instruction illegal:
  - illegal_inst = 1.
  - All other combinational outputs are forced to 0 (safe NOP: no register or memory write).
- inst[1:0] != 11 is illegal. The all-zero word is therefore illegal.
- illegal_seen updates on the rising edge of clk:
  - When rst = 1, it loads 0 (rst takes priority).
  - Otherwise it loads illegal_seen | illegal_inst.
- When rst and an illegal inst occur in the same cycle, the flag clears.

Decomposition:
- ctrl_pkg holds:
  - opcode constants;
  - alu_ctrl codes;
  - wb-select codes WB_ALU, WB_MEM, WB_PC4;
  - memory size codes.
- Optional sub-module ctrl_legal_chk computes illegal_inst from inst. The main body is a single case on opcode plus the sticky flop.

Test Plan:
- LUI 0x80000037 -> alu 10000, wr_en 1, wb 00, op2_sel 1, mem_wr 0, jal/jalr 0, illegal 0. AUIPC 0x80000017 -> alu 10001, same other fields.
- JAL 0x8020006F -> jal 1, wr_en 1, wb 10. JALR 0x80000067 -> jalr 1, wr_en 1, wb 10, op2_sel 1. JALR with funct3 = 001 -> illegal, all outputs 0.
- BEQ 0x800000E3 -> alu 11000, wr_en 0, mem_wr 0. LB 0x80000003 -> wr_en 1, wb 01, size 00, sz_ex 1. LHU -> size 01, sz_ex 0. SB 0x80000823 -> mem_wr 1, size 00, wr_en 0.
- SLTIU 0x80003013 -> alu 00011, op2_sel 1. SRAI 0x41005013 -> alu 01101. SUB (0x40000033) -> alu 01000. SLL with funct7 0100000 -> illegal.
- 0x00000000 -> illegal_inst 1, all other outputs 0. illegal_seen rises on the next edge and holds through later legal instructions.
- Assert rst for one cycle -> illegal_seen clears. rst coincident with illegal inst -> illegal_seen stays 0.
